spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
- SPI target (responder) for the SoC's SPI controller pins (sclk, pico, poci, cs); lets an external SPI controller exchange bytes with on-board logic.
- Oversamples all SPI inputs with the system clock through 2-flop synchronizers and edge-detects sclk.
- Exposes byte-wide receive strobes and a one-entry transmit holding register with a valid/ready handshake.
- Full-duplex, MSB first, 8-bit frames, mode fixed by parameters.

Parameters:
- CPOL, 0: sclk idle level.
- CPHA, 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- IDLE_TX_BYTE, 8'hFF: byte shifted out when no tx byte is held.

Ports:
- clock  input  1  system clock; must be at least 8x the sclk frequency.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from controller (asynchronous).
- pico  input  1  controller-to-peripheral data (asynchronous).
- cs  input  1  chip select, active-low (asynchronous).
- poci  output  1  peripheral-to-controller data.
- poci_oe  output  1  high while cs is asserted (synchronized view).
- tx_data  input  8  next byte to send.
- tx_valid  input  1  tx_data offered.
- tx_ready  output  1  holding register empty.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle strobe, rx_data updated.
- tx_underrun  output  1  one-cycle strobe, IDLE_TX_BYTE was loaded because the holding register was empty.
- busy  output  1  high while cs is asserted.

Behaviour:
- Reset (reset=0, asynchronous): poci=0, poci_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, bit_cnt=0, holding register empty. Synchronizer flops reset to the idle levels (sclk=CPOL, cs=1, pico=0).
- Synchronization: sclk, pico and cs pass through 2 flops. Edges are detected from the 2nd and 3rd flop, giving 3 clock cycles of latency from pin to internal event.
- Leading edge = sclk transition away from CPOL; trailing edge = transition back to CPOL.
- Tx handshake: transfer occurs when tx_valid && tx_ready at a rising clock edge. tx_ready falls the next cycle and rises again the cycle after the holding byte moves into the shift register. Accepted at any time, including while cs is high.
- States:
  - IDLE (cs high): poci=0, poci_oe=0, busy=0, bit_cnt=0.
  - IDLE -> ACTIVE on synchronized cs falling edge. The load event fires, then busy=1 and poci_oe=1.
  - ACTIVE -> IDLE on synchronized cs rising edge, from any bit position.
- Load event: the shift register takes the holding byte (holding becomes empty) or IDLE_TX_BYTE with a tx_underrun pulse. bit_cnt=0.
  - CPHA=0: load on cs fall, poci=bit7 immediately. Each trailing edge shifts the next bit out. Each leading edge samples pico into rx_shift.
  - CPHA=1: load on cs fall, poci driven from the first leading edge. Each leading edge shifts a bit out; each trailing edge samples pico.
- Byte completion: on the 8th sample edge:
  - rx_data <= {rx_shift[6:0], pico_sync}; rx_valid pulses the same cycle rx_data updates.
  - bit_cnt wraps to 0 and the next load event occurs at the next shift edge. CPHA=0: bit7 of the next byte is driven on that trailing edge.
- Back-to-back bytes without cs deassertion are supported indefinitely.
- Simultaneous events:
  - tx handshake in the same cycle as a load event: the load takes the old holding content (or underruns) and the new byte enters holding. No byte is lost.
  - If holding is full, tx_ready=0 and no handshake is possible.
- cs deasserted mid-byte: partial rx bits discarded, no rx_valid. The byte in the shift register is counted as consumed. bit_cnt=0 and poci=0 next cycle.
- sclk edges while cs is high are ignored.
- rx has no backpressure. The consumer must take rx_data within 8 sclk periods; otherwise rx_data is overwritten.
- Asynchronous reset mid-transfer returns everything to reset values immediately. The holding byte is lost.

Test Plan:
- Mode 0, sclk = clock/16. Preload tx 8'hA5, controller sends 8'h3C -> controller reads 8'hA5; rx_valid pulses once with rx_data=8'h3C; tx_ready returns to 1.
- Mode 0, two back-to-back bytes without cs deassertion. Tx 8'h12 preloaded; 8'h34 offered after the first load; controller sends 8'hC1, 8'h7E -> poci yields 12,34; rx_valid pulses twice with C1 then 7E.
- No tx byte held, controller clocks 8 bits -> poci yields 8'hFF; tx_underrun pulses once; rx byte still received.
- CPOL=1, CPHA=1 instance. Tx 8'h81, rx 8'h55 -> controller reads 8'h81; rx_data=8'h55.
- cs raised after 5 bits -> no rx_valid; poci=0 and busy=0 within 4 clocks. Next frame with tx 8'h0F transfers correctly from bit7.
- reset asserted mid-byte (bit 3) -> all outputs at reset values asynchronously. After release, a fresh 8'hE7 exchange completes correctly.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI target with oversampled pins, one-entry tx holding register and byte-wide rx strobe.
// Frames are 8 bits, MSB first, full duplex; clock polarity and phase are fixed at build time.
module spi_peripheral #(
  parameter bit         CPOL         = 1'b0,
  parameter bit         CPHA         = 1'b0,
  parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       pico,
  input  logic       cs,
  output logic       poci,
  output logic       poci_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  state_e     state_q;
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] pico_sync_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] tx_shift_q;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_data_q;
  logic [2:0] bit_cnt_q;
  logic       load_pend_q;
  logic       poci_q;
  logic       rx_valid_q;
  logic       underrun_q;

  logic       sclk_lead;
  logic       sclk_trail;
  logic       sample_edge;
  logic       shift_edge;
  logic       cs_fall;
  logic       cs_rise;
  logic       pico_s;
  logic       tx_fire;
  logic       do_load;
  logic [7:0] load_byte_d;
  logic [7:0] rx_byte_d;

  // Bit [1] is the second synchronizer flop; bit [2] only serves edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= {3{CPOL}};
      cs_sync_q   <= 3'b111;
      pico_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], cs};
      pico_sync_q <= {pico_sync_q[0], pico};
    end
  end

  assign sclk_lead   = (sclk_sync_q[1] != CPOL) && (sclk_sync_q[2] == CPOL);
  assign sclk_trail  = (sclk_sync_q[1] == CPOL) && (sclk_sync_q[2] != CPOL);
  assign sample_edge = CPHA ? sclk_trail : sclk_lead;
  assign shift_edge  = CPHA ? sclk_lead : sclk_trail;
  assign cs_fall     = !cs_sync_q[1] && cs_sync_q[2];
  assign cs_rise     = cs_sync_q[1] && !cs_sync_q[2];
  assign pico_s      = pico_sync_q[1];

  assign tx_fire     = tx_valid && !hold_full_q;
  assign load_byte_d = hold_full_q ? hold_q : IDLE_TX_BYTE;
  assign rx_byte_d   = {rx_shift_q[6:0], pico_s};
  assign do_load     = (state_q == S_IDLE) ? cs_fall
                                           : (!cs_rise && shift_edge && load_pend_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      load_pend_q <= 1'b0;
      poci_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      // A load and a handshake never both touch hold_full_q: a handshake needs it clear.
      if (do_load) begin
        if (hold_full_q) hold_full_q <= 1'b0;
        else             underrun_q  <= 1'b1;
      end
      if (tx_fire) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_q     <= S_ACTIVE;
            bit_cnt_q   <= 3'd0;
            load_pend_q <= 1'b0;
            if (CPHA) begin
              tx_shift_q <= load_byte_d;
              poci_q     <= 1'b0;
            end else begin
              tx_shift_q <= {load_byte_d[6:0], 1'b0};
              poci_q     <= load_byte_d[7];
            end
          end
        end
        S_ACTIVE: begin
          if (cs_rise) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            load_pend_q <= 1'b0;
            poci_q      <= 1'b0;
          end else if (shift_edge) begin
            if (load_pend_q) begin
              load_pend_q <= 1'b0;
              tx_shift_q  <= {load_byte_d[6:0], 1'b0};
              poci_q      <= load_byte_d[7];
            end else begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              poci_q     <= tx_shift_q[7];
            end
          end else if (sample_edge) begin
            rx_shift_q <= rx_byte_d;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q   <= rx_byte_d;
              rx_valid_q  <= 1'b1;
              bit_cnt_q   <= 3'd0;
              load_pend_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign poci        = poci_q;
  assign poci_oe     = (state_q == S_ACTIVE);
  assign busy        = (state_q == S_ACTIVE);
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a mode-0 instance and a CPOL=1/CPHA=1 instance driven by a
// behavioural SPI controller; received bytes are scoreboarded against expected queues.
module tb_spi_peripheral;

  localparam int H = 8;  // sclk half period in system clocks (sclk = clock/16)

  logic       clock;
  logic       reset;
  logic       sclk0, pico0, cs0, poci0, poci_oe0, tx_valid0, tx_ready0, rx_valid0, tx_underrun0, busy0;
  logic [7:0] tx_data0, rx_data0;
  logic       sclk1, pico1, cs1, poci1, poci_oe1, tx_valid1, tx_ready1, rx_valid1, tx_underrun1, busy1;
  logic [7:0] tx_data1, rx_data1;

  int checks = 0;
  int failures = 0;
  int rxv_cnt0 = 0, rxv_cnt1 = 0;
  int under_cnt0 = 0, under_cnt1 = 0;
  logic [7:0] rx_q0[$];
  logic [7:0] rx_q1[$];

  spi_peripheral #(.CPOL(1'b0), .CPHA(1'b0), .IDLE_TX_BYTE(8'hFF)) dut0 (
    .clock(clock), .reset(reset), .sclk(sclk0), .pico(pico0), .cs(cs0),
    .poci(poci0), .poci_oe(poci_oe0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_underrun(tx_underrun0), .busy(busy0));

  spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1), .IDLE_TX_BYTE(8'hFF)) dut1 (
    .clock(clock), .reset(reset), .sclk(sclk1), .pico(pico1), .cs(cs1),
    .poci(poci1), .poci_oe(poci_oe1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_underrun(tx_underrun1), .busy(busy1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitors: every rx_valid strobe must match the oldest expected byte.
  always @(negedge clock) begin
    if (rx_valid0 === 1'b1) begin
      rxv_cnt0++;
      if (rx_q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx0_unexpected got=%0h expected=none", rx_data0);
      end else begin
        check("rx0_data", {24'd0, rx_data0}, {24'd0, rx_q0.pop_front()});
      end
    end
    if (tx_underrun0 === 1'b1) under_cnt0++;
  end

  always @(negedge clock) begin
    if (rx_valid1 === 1'b1) begin
      rxv_cnt1++;
      if (rx_q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx1_unexpected got=%0h expected=none", rx_data1);
      end else begin
        check("rx1_data", {24'd0, rx_data1}, {24'd0, rx_q1.pop_front()});
      end
    end
    if (tx_underrun1 === 1'b1) under_cnt1++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tx_send(input int sel, input logic [7:0] b);
    int n;
    logic rdy;
    n = 0;
    @(negedge clock);
    rdy = (sel == 0) ? tx_ready0 : tx_ready1;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clock);
      rdy = (sel == 0) ? tx_ready0 : tx_ready1;
      n++;
    end
    check("tx_ready_wait", {31'd0, rdy}, 32'd1);
    if (rdy === 1'b1) begin
      if (sel == 0) begin tx_data0 = b; tx_valid0 = 1'b1; end
      else          begin tx_data1 = b; tx_valid1 = 1'b1; end
      @(posedge clock);
      #1;
      tx_valid0 = 1'b0;
      tx_valid1 = 1'b0;
    end
  endtask

  task automatic frame_start(input int sel);
    if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end(input int sel);
    wait_clk(H);
    if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
    wait_clk(2 * H);
  endtask

  // Controller side: instance 0 is mode 0, instance 1 is CPOL=1/CPHA=1.
  task automatic spi_bits(input int sel, input logic [7:0] dout, input int nbits,
                          output logic [7:0] din);
    din = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) begin
        pico0 = dout[7-i];
        wait_clk(H);
        din = {din[6:0], poci0};
        sclk0 = 1'b1;
        wait_clk(H);
        sclk0 = 1'b0;
      end else begin
        sclk1 = 1'b0;
        pico1 = dout[7-i];
        wait_clk(H);
        din = {din[6:0], poci1};
        sclk1 = 1'b1;
        wait_clk(H);
      end
    end
  endtask

  task automatic xfer(input int sel, input logic [7:0] mosi, input logic [7:0] exp_miso,
                      input string name);
    logic [7:0] din;
    if (sel == 0) rx_q0.push_back(mosi); else rx_q1.push_back(mosi);
    spi_bits(sel, mosi, 8, din);
    check(name, {24'd0, din}, {24'd0, exp_miso});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_poci0"},     {31'd0, poci0},        32'd0);
    check({tag, "_poci_oe0"},  {31'd0, poci_oe0},     32'd0);
    check({tag, "_tx_ready0"}, {31'd0, tx_ready0},    32'd1);
    check({tag, "_rx_data0"},  {24'd0, rx_data0},     32'd0);
    check({tag, "_rx_valid0"}, {31'd0, rx_valid0},    32'd0);
    check({tag, "_underrun0"}, {31'd0, tx_underrun0}, 32'd0);
    check({tag, "_busy0"},     {31'd0, busy0},        32'd0);
  endtask

  initial begin
    int rv, uc;
    logic [7:0] din;
    reset = 1'b0;
    sclk0 = 1'b0; pico0 = 1'b0; cs0 = 1'b1; tx_data0 = 8'h00; tx_valid0 = 1'b0;
    sclk1 = 1'b1; pico1 = 1'b0; cs1 = 1'b1; tx_data1 = 8'h00; tx_valid1 = 1'b0;
    wait_clk(3);
    check_reset_outputs("rst");
    check("rst_poci_oe1", {31'd0, poci_oe1}, 32'd0);
    check("rst_tx_ready1", {31'd0, tx_ready1}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    reset = 1'b1;
    wait_clk(4);

    // Single mode-0 byte
    tx_send(0, 8'hA5);
    @(negedge clock);
    check("t1_ready_low", {31'd0, tx_ready0}, 32'd0);
    rv = rxv_cnt0;
    frame_start(0);
    check("t1_busy", {31'd0, busy0}, 32'd1);
    check("t1_poci_oe", {31'd0, poci_oe0}, 32'd1);
    xfer(0, 8'h3C, 8'hA5, "t1_miso");
    frame_end(0);
    check("t1_ready_back", {31'd0, tx_ready0}, 32'd1);
    check("t1_rx_pulses", rxv_cnt0 - rv, 32'd1);
    check("t1_busy_idle", {31'd0, busy0}, 32'd0);

    // Back-to-back bytes in one frame
    rv = rxv_cnt0;
    tx_send(0, 8'h12);
    frame_start(0);
    tx_send(0, 8'h34);
    xfer(0, 8'hC1, 8'h12, "t2_miso0");
    xfer(0, 8'h7E, 8'h34, "t2_miso1");
    frame_end(0);
    check("t2_rx_pulses", rxv_cnt0 - rv, 32'd2);

    // Empty holding register at frame start
    rv = rxv_cnt0;
    uc = under_cnt0;
    frame_start(0);
    tx_send(0, 8'h5A);
    xfer(0, 8'h96, 8'hFF, "t3_miso_idle");
    frame_end(0);
    check("t3_underrun_pulses", under_cnt0 - uc, 32'd1);
    check("t3_rx_pulses", rxv_cnt0 - rv, 32'd1);
    check("t3_ready", {31'd0, tx_ready0}, 32'd1);

    // CPOL=1, CPHA=1 instance
    tx_send(1, 8'h81);
    frame_start(1);
    check("t4_busy", {31'd0, busy1}, 32'd1);
    xfer(1, 8'h55, 8'h81, "t4_miso");
    frame_end(1);
    check("t4_rx_data", {24'd0, rx_data1}, 32'h55);
    check("t4_no_underrun", under_cnt1, 32'd0);
    check("t4_rx_pulses", rxv_cnt1, 32'd1);

    // Frame aborted after 5 bits
    rv = rxv_cnt0;
    frame_start(0);
    spi_bits(0, 8'hB4, 5, din);
    check("t5_partial_miso", {27'd0, din[4:0]}, 32'h1F);
    check("t5_busy_mid", {31'd0, busy0}, 32'd1);
    check("t5_poci_mid", {31'd0, poci0}, 32'd1);
    cs0 = 1'b1;
    wait_clk(4);
    check("t5_busy_off", {31'd0, busy0}, 32'd0);
    check("t5_poci_off", {31'd0, poci0}, 32'd0);
    check("t5_oe_off", {31'd0, poci_oe0}, 32'd0);
    wait_clk(2 * H);
    check("t5_no_rx", rxv_cnt0 - rv, 32'd0);
    tx_send(0, 8'h0F);
    frame_start(0);
    xfer(0, 8'hC3, 8'h0F, "t5_next_miso");
    frame_end(0);
    check("t5_next_rx", {24'd0, rx_data0}, 32'hC3);

    // Asynchronous reset during bit 3
    frame_start(0);
    spi_bits(0, 8'h5B, 3, din);
    pico0 = 1'b1;
    wait_clk(2);
    tx_send(0, 8'h44);
    @(negedge clock);
    check("t6_ready_full", {31'd0, tx_ready0}, 32'd0);
    check("t6_poci_pre", {31'd0, poci0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6");
    cs0 = 1'b1; sclk0 = 1'b0; pico0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_clk(4);
    check("t6_ready_after", {31'd0, tx_ready0}, 32'd1);
    tx_send(0, 8'hE7);
    frame_start(0);
    xfer(0, 8'hE7, 8'hE7, "t6_fresh_miso");
    frame_end(0);
    check("t6_fresh_rx", {24'd0, rx_data0}, 32'hE7);

    check("rx_q0_drained", rx_q0.size(), 32'd0);
    check("rx_q1_drained", rx_q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
